// File: rtl/hex_lock_ctrl.sv
// hex_lock_ctrl: 4-digit hex password lock sequencer; optional entry timeout via HEX_LOCK_ENTRY_TIMEOUT_EN
module hex_lock_ctrl #(
  parameter logic [15:0] DEFAULT_PSWD   = 16'hA5C3,
  parameter int          MAX_TRIES      = 3,
  parameter int          LOCKOUT_CYCLES = 1000,
  parameter int          UNLOCK_CYCLES  = 500,
  parameter int          ENTRY_TIMEOUT  = 200
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             key_valid,
  input  logic [3:0]                       key_data,
  input  logic                             chg_req,
  output logic                             lock,
  output logic                             buzzer,
  output logic                             err,
  output logic                             pw_updated,
  output logic [$clog2(MAX_TRIES+1)-1:0]   attempts,
  output logic [2:0]                       state
);
  localparam int AW   = $clog2(MAX_TRIES + 1);
  localparam int TMAX = LOCKOUT_CYCLES > UNLOCK_CYCLES ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  typedef enum logic [2:0] {IDLE, ENTRY, CHECK, OPEN, NEWPW, LOCKOUT} st_t;
  st_t             st;
  logic [1:0]      dcnt;
  logic            mm;
  logic [0:3][3:0] pw, sh;
  logic [TW-1:0]   tmr;
  logic [AW-1:0]   att_nxt;
`ifdef HEX_LOCK_ENTRY_TIMEOUT_EN
  localparam int IW = $clog2(ENTRY_TIMEOUT + 1);
  logic [IW-1:0]   icnt;
`else
  logic            unused_to;
  assign unused_to = ENTRY_TIMEOUT > 0;
`endif
  assign att_nxt = attempts == AW'(MAX_TRIES) ? attempts : attempts + AW'(1);
  assign state   = st;
  // Sequencer: digit collection, compare, unlock/lockout timing and password commit
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st         <= IDLE;
      dcnt       <= '0;
      mm         <= 1'b0;
      pw         <= DEFAULT_PSWD;
      sh         <= '0;
      tmr        <= '0;
      lock       <= 1'b1;
      buzzer     <= 1'b0;
      err        <= 1'b0;
      pw_updated <= 1'b0;
      attempts   <= '0;
`ifdef HEX_LOCK_ENTRY_TIMEOUT_EN
      icnt       <= '0;
`endif
    end else begin
      err        <= 1'b0;
      pw_updated <= 1'b0;
      case (st)
        IDLE: if (key_valid) begin
          mm   <= key_data != pw[0];
          dcnt <= 2'd1;
          st   <= ENTRY;
`ifdef HEX_LOCK_ENTRY_TIMEOUT_EN
          icnt <= '0;
`endif
        end
        ENTRY: if (key_valid) begin
          mm   <= mm | (key_data != pw[dcnt]);
          dcnt <= dcnt + 2'd1;
          if (dcnt == 2'd3) st <= CHECK;
`ifdef HEX_LOCK_ENTRY_TIMEOUT_EN
          icnt <= '0;
        end else if (icnt == IW'(ENTRY_TIMEOUT - 1)) begin
          st   <= IDLE;
          dcnt <= '0;
        end else begin
          icnt <= icnt + IW'(1);
`endif
        end
        CHECK: if (!mm) begin
          attempts <= '0;
          lock     <= 1'b0;
          tmr      <= '0;
          st       <= OPEN;
        end else begin
          err      <= 1'b1;
          attempts <= att_nxt;
          if (att_nxt == AW'(MAX_TRIES)) begin
            buzzer <= 1'b1;
            tmr    <= '0;
            st     <= LOCKOUT;
          end else st <= IDLE;
        end
        OPEN: if (chg_req) begin
          dcnt <= '0;
          st   <= NEWPW;
`ifdef HEX_LOCK_ENTRY_TIMEOUT_EN
          icnt <= '0;
`endif
        end else if (tmr == TW'(UNLOCK_CYCLES - 1)) begin
          lock <= 1'b1;
          st   <= IDLE;
        end else tmr <= tmr + TW'(1);
        NEWPW: if (key_valid) begin
          sh[dcnt] <= key_data;
          dcnt     <= dcnt + 2'd1;
          if (dcnt == 2'd3) begin
            pw         <= {sh[0], sh[1], sh[2], key_data};
            pw_updated <= 1'b1;
            lock       <= 1'b1;
            st         <= IDLE;
          end
`ifdef HEX_LOCK_ENTRY_TIMEOUT_EN
          icnt <= '0;
        end else if (icnt == IW'(ENTRY_TIMEOUT - 1)) begin
          dcnt <= '0;
          lock <= 1'b1;
          st   <= IDLE;
        end else begin
          icnt <= icnt + IW'(1);
`endif
        end
        LOCKOUT: if (tmr == TW'(LOCKOUT_CYCLES - 1)) begin
          buzzer   <= 1'b0;
          attempts <= '0;
          st       <= IDLE;
        end else tmr <= tmr + TW'(1);
        default: begin
          lock   <= 1'b1;
          buzzer <= 1'b0;
          st     <= IDLE;
        end
      endcase
    end
endmodule
